// File: rtl/jump_ctr.sv
// rtl/jump_ctr.sv - branch decision unit: PC-source select, registered copy, illegal-code flag
// Optional taken/not-taken counters are built when JUMP_CTR_STATS_EN is defined.
module jump_ctr #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             BE,
  input  logic [2:0]       BS,
  input  logic             ZERO,
  input  logic             SLT,
  input  logic             SLTU,
  output logic             PCS,
  output logic             PCS_R,
  output logic             ILL
`ifdef JUMP_CTR_STATS_EN
  ,
  output logic [CNT_W-1:0] TAKEN_CNT,
  output logic [CNT_W-1:0] NTAKEN_CNT
`endif
);

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  // An unknown BS matches no case item and falls to the not-taken default.
  always_comb begin
    PCS = 1'b0;
    ILL = 1'b0;
    if (BE) begin
      case (BS)
        3'b000:  PCS = ZERO;
        3'b001:  PCS = ~ZERO;
        3'b010:  PCS = SLT;
        3'b011:  PCS = ~SLT;
        3'b110:  PCS = SLTU;
        3'b111:  PCS = ~SLTU;
        3'b100:  ILL = 1'b1;
        3'b101:  ILL = 1'b1;
        default: begin
          PCS = 1'b0;
          ILL = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PCS_R <= 1'b0;
    end else begin
      PCS_R <= PCS;
    end
  end

`ifdef JUMP_CTR_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      TAKEN_CNT  <= '0;
      NTAKEN_CNT <= '0;
    end else if (BE && !ILL) begin
      if (PCS) begin
        TAKEN_CNT <= TAKEN_CNT + 1'b1;
      end else begin
        NTAKEN_CNT <= NTAKEN_CNT + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_jump_ctr.sv
// tb/tb_jump_ctr.sv - self-checking bench for jump_ctr
// Counter checks are compiled in when JUMP_CTR_STATS_EN is defined.
module tb_jump_ctr;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             BE;
  logic [2:0]       BS;
  logic             ZERO;
  logic             SLT;
  logic             SLTU;
  logic             PCS;
  logic             PCS_R;
  logic             ILL;
`ifdef JUMP_CTR_STATS_EN
  logic [CNT_W-1:0] TAKEN_CNT;
  logic [CNT_W-1:0] NTAKEN_CNT;
`endif

  int errors = 0;
  int checks = 0;

  jump_ctr #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .BE    (BE),
    .BS    (BS),
    .ZERO  (ZERO),
    .SLT   (SLT),
    .SLTU  (SLTU),
    .PCS   (PCS),
    .PCS_R (PCS_R),
    .ILL   (ILL)
`ifdef JUMP_CTR_STATS_EN
    ,
    .TAKEN_CNT  (TAKEN_CNT),
    .NTAKEN_CNT (NTAKEN_CNT)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic be, input logic [2:0] bs,
                       input logic z, input logic lt, input logic ltu);
    BE   = be;
    BS   = bs;
    ZERO = z;
    SLT  = lt;
    SLTU = ltu;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checks++;
    if (PCS_R !== 1'b0) begin
      errors++;
      $display("FAIL reset_pcs_r: got %b want 0", PCS_R);
    end
    checks++;
    if (ILL !== 1'b0 || PCS !== 1'b0) begin
      errors++;
      $display("FAIL reset_comb_idle: got pcs=%b ill=%b want 0/0", PCS, ILL);
    end
    // Combinational outputs keep working while reset is held.
    drive(1'b1, 3'b000, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checks++;
    if (PCS !== 1'b1 || PCS_R !== 1'b0) begin
      errors++;
      $display("FAIL reset_comb_live: got pcs=%b pcs_r=%b want 1/0", PCS, PCS_R);
    end
    drive(1'b1, 3'b101, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (ILL !== 1'b1) begin
      errors++;
      $display("FAIL reset_ill_live: got %b want 1", ILL);
    end
    @(negedge clk);
    drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_disabled;
    logic [2:0] bs_v [4];
    logic       fl_v [4];
    bs_v = '{3'b000, 3'b000, 3'b100, 3'b111};
    fl_v = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b0, bs_v[i], fl_v[i], fl_v[i], fl_v[i]);
      #1;
      checks++;
      if (PCS !== 1'b0 || ILL !== 1'b0) begin
        errors++;
        $display("FAIL disabled_%0d: got pcs=%b ill=%b want 0/0", i, PCS, ILL);
      end
    end
  endtask

  // Each row: {bs, zero, slt, sltu, expected pcs}
  task automatic test_conditions;
    logic [6:0] vec [16];
    vec = '{
      {3'b000, 1'b1, 1'b0, 1'b0, 1'b1},
      {3'b000, 1'b0, 1'b0, 1'b0, 1'b0},
      {3'b000, 1'b1, 1'b1, 1'b1, 1'b1},
      {3'b000, 1'b0, 1'b1, 1'b1, 1'b0},
      {3'b001, 1'b1, 1'b0, 1'b0, 1'b0},
      {3'b001, 1'b0, 1'b0, 1'b0, 1'b1},
      {3'b010, 1'b0, 1'b0, 1'b1, 1'b0},
      {3'b010, 1'b0, 1'b1, 1'b1, 1'b1},
      {3'b011, 1'b0, 1'b1, 1'b1, 1'b0},
      {3'b011, 1'b0, 1'b0, 1'b1, 1'b1},
      {3'b110, 1'b0, 1'b0, 1'b0, 1'b0},
      {3'b110, 1'b0, 1'b0, 1'b1, 1'b1},
      {3'b111, 1'b0, 1'b0, 1'b1, 1'b0},
      {3'b111, 1'b0, 1'b0, 1'b0, 1'b1},
      {3'b110, 1'b1, 1'b1, 1'b0, 1'b0},
      {3'b010, 1'b1, 1'b0, 1'b1, 1'b0}
    };
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(1'b1, vec[i][6:4], vec[i][3], vec[i][2], vec[i][1]);
      #1;
      checks++;
      if (PCS !== vec[i][0] || ILL !== 1'b0) begin
        errors++;
        $display("FAIL cond_%0d bs=%b: got pcs=%b ill=%b want %b/0",
                 i, vec[i][6:4], PCS, ILL, vec[i][0]);
      end
    end
  endtask

  task automatic test_reserved;
    @(negedge clk);
    drive(1'b1, 3'b100, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (PCS !== 1'b0 || ILL !== 1'b1) begin
      errors++;
      $display("FAIL reserved_100: got pcs=%b ill=%b want 0/1", PCS, ILL);
    end
    drive(1'b1, 3'b101, 1'b1, 1'b1, 1'b1);
    #1;
    checks++;
    if (PCS !== 1'b0 || ILL !== 1'b1) begin
      errors++;
      $display("FAIL reserved_101: got pcs=%b ill=%b want 0/1", PCS, ILL);
    end
    BE = 1'b0;
    #1;
    checks++;
    if (ILL !== 1'b0) begin
      errors++;
      $display("FAIL reserved_be_drop: got ill=%b want 0", ILL);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] bs_v [5];
    logic       z_v  [5];
    logic       exp_v[5];
    bs_v  = '{3'b000, 3'b001, 3'b000, 3'b001, 3'b000};
    z_v   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_v = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1'b1, bs_v[i], z_v[i], 1'b0, 1'b0);
      @(posedge clk);
      #1;
      checks++;
      if (PCS_R !== exp_v[i]) begin
        errors++;
        $display("FAIL b2b_pcs_r_%0d: got %b want %b", i, PCS_R, exp_v[i]);
      end
    end
  endtask

  task automatic test_pcs_r_reset;
    @(negedge clk);
    drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 3'b000, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (PCS_R !== 1'b0) begin
      errors++;
      $display("FAIL pcs_r_before_edge: got %b want 0", PCS_R);
    end
    @(posedge clk);
    #1;
    checks++;
    if (PCS_R !== 1'b1) begin
      errors++;
      $display("FAIL pcs_r_after_edge: got %b want 1", PCS_R);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (PCS_R !== 1'b0 || PCS !== 1'b1) begin
      errors++;
      $display("FAIL pcs_r_async_clear: got pcs_r=%b pcs=%b want 0/1", PCS_R, PCS);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
  endtask

`ifdef JUMP_CTR_STATS_EN
  // Each row: {be, bs, zero}; taken rows counted as 3, not-taken as 2.
  task automatic test_stats;
    logic [4:0] vec [7];
    vec = '{
      {1'b1, 3'b000, 1'b1},
      {1'b1, 3'b001, 1'b1},
      {1'b1, 3'b100, 1'b1},
      {1'b1, 3'b001, 1'b0},
      {1'b0, 3'b000, 1'b1},
      {1'b1, 3'b000, 1'b0},
      {1'b1, 3'b000, 1'b1}
    };
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(vec[i][4], vec[i][3:1], vec[i][0], 1'b0, 1'b0);
      @(negedge clk);
    end
    drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    checks++;
    if (TAKEN_CNT !== 16'd3 || NTAKEN_CNT !== 16'd2) begin
      errors++;
      $display("FAIL stats_counts: got taken=%0d ntaken=%0d want 3/2",
               TAKEN_CNT, NTAKEN_CNT);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (TAKEN_CNT !== 16'd0 || NTAKEN_CNT !== 16'd0) begin
      errors++;
      $display("FAIL stats_clear: got taken=%0d ntaken=%0d want 0/0",
               TAKEN_CNT, NTAKEN_CNT);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_disabled();
    test_conditions();
    test_reserved();
    test_back_to_back();
    test_pcs_r_reset();
`ifdef JUMP_CTR_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
